// File: rtl/hms_pkg.sv
// hms_pkg -- shared definitions for the HMS timekeeper.
//   state_e    : FSM state encoding (also exported on state_o)
//   ADDR_*     : parallel-load target codes presented on addr
//   MAX_*      : field limits used for wrap and load range checks
//   h24_to_12  : 24-hour value -> {am_pm_bar, 12-hour value}
package hms_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PAUSE   = 3'd1,
    ST_SET_AP  = 3'd2,
    ST_SET_HR  = 3'd3,
    ST_SET_MIN = 3'd4,
    ST_SET_SEC = 3'd5
  } state_e;

  localparam logic [2:0] ADDR_SEC     = 3'd1;
  localparam logic [2:0] ADDR_MIN     = 3'd2;
  localparam logic [2:0] ADDR_HOUR    = 3'd3;
  localparam logic [2:0] ADDR_ALM_HR  = 3'd4;
  localparam logic [2:0] ADDR_ALM_MIN = 3'd5;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [4:0] MAX_H24 = 5'd23;

  // Midnight shows as 12 AM, noon as 12 PM, 13..23 fold down to 1..11.
  function automatic logic [5:0] h24_to_12(input logic [4:0] h24);
    logic       am;
    logic [4:0] hr12;
    am = (h24 < 5'd12);
    if (h24 == 5'd0)
      hr12 = 5'd12;
    else if (h24 > 5'd12)
      hr12 = h24 - 5'd12;
    else
      hr12 = h24;
    return {am, hr12};
  endfunction

endpackage

// File: rtl/hms_prescaler.sv
// hms_prescaler -- divides clk down to a one-cycle seconds tick.
//   clk  in  : clock
//   rst  in  : synchronous active-low reset
//   en   in  : count enable; when low the counter is held at 0
//   tick out : high in the last cycle of each TICK_DIV-cycle period while en=1
// Parameter TICK_DIV (>=1): clk cycles per tick.
module hms_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Gating tick with en keeps TICK_DIV=1 (counter pinned at 0) from
  // ticking while the clock is stopped.
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || tick)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hms_timekeeper_cfg.sv
// hms_timekeeper_cfg -- run/pause/set HMS clock, stored in 24-hour form,
// displayed in 12- or 24-hour form chosen by fmt_24.
//   clk, rst          : clock, synchronous active-low reset
//   ss, sel           : start/stop (dominant), advance set field
//   inc, dec          : step the field being set (both high = no change)
//   load, addr, din   : parallel load in PAUSE (1=sec 2=min 3=hour 4/5=alarm)
//   fmt_24            : 1 = 24-hour display, 0 = 12-hour display
//   hrs, min, sec     : displayed time
//   am_pm_bar         : 1 = AM (always 1 in 24-hour display)
//   day_pulse         : one cycle at the 23:59:59 -> 00:00:00 rollover
//   state_o           : FSM state for the display blink logic
//   alarm_arm/ack/o   : present only when HMS_ALARM_EN is defined
// Parameters: TICK_DIV (clk cycles per second, >=1), DIN_W (din width, >=6).
// Build option: define HMS_ALARM_EN to add the hour/minute alarm.
module hms_timekeeper_cfg
  import hms_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int DIN_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sel,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [2:0]       addr,
  input  logic [DIN_W-1:0] din,
  input  logic             fmt_24,
  output logic [4:0]       hrs,
  output logic [5:0]       min,
  output logic [5:0]       sec,
  output logic             am_pm_bar,
  output logic             day_pulse,
  output logic [2:0]       state_o
`ifdef HMS_ALARM_EN
  ,
  input  logic             alarm_arm,
  input  logic             alarm_ack,
  output logic             alarm_o
`endif
);

  state_e     state_q, state_d;
  logic [4:0] h24_q, h24_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       day_pulse_q, day_pulse_d;
  logic       run_en, tick, tick_upd;
  logic       step_up, step_dn;
  logic [5:0] disp12;
`ifdef HMS_ALARM_EN
  logic [4:0] alarm_h24_q, alarm_h24_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic       alarm_o_q, alarm_o_d;
`endif

  assign run_en = (state_q == ST_RUN);

  hms_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .tick (tick)
  );

  // Next-state logic; ss beats sel everywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (ss) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (ss)       state_d = ST_RUN;
        else if (sel) state_d = fmt_24 ? ST_SET_HR : ST_SET_AP;
      end
      ST_SET_AP: begin
        if (ss)       state_d = ST_RUN;
        else if (sel) state_d = ST_SET_HR;
      end
      ST_SET_HR: begin
        if (ss)       state_d = ST_RUN;
        else if (sel) state_d = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        if (ss)       state_d = ST_RUN;
        else if (sel) state_d = ST_SET_SEC;
      end
      ST_SET_SEC: begin
        if (ss)       state_d = ST_RUN;
        else if (sel) state_d = ST_SET_HR;
      end
      default:        state_d = ST_RUN;
    endcase
  end

  // Field updates are keyed on the current state. Any cycle with ss high
  // is a RUN entry/exit, so it leaves the time untouched.
  always_comb begin
    h24_d       = h24_q;
    min_d       = min_q;
    sec_d       = sec_q;
    day_pulse_d = 1'b0;
    tick_upd    = 1'b0;
    step_up     = inc & ~dec;
    step_dn     = dec & ~inc;
`ifdef HMS_ALARM_EN
    alarm_h24_d = alarm_h24_q;
    alarm_min_d = alarm_min_q;
    alarm_o_d   = alarm_o_q;
`endif
    if (!ss) begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            tick_upd = 1'b1;
            if (sec_q == MAX_SEC) begin
              sec_d = '0;
              if (min_q == MAX_MIN) begin
                min_d = '0;
                if (h24_q == MAX_H24) begin
                  h24_d       = '0;
                  day_pulse_d = 1'b1;
                end else begin
                  h24_d = h24_q + 5'd1;
                end
              end else begin
                min_d = min_q + 6'd1;
              end
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end
        end
        ST_PAUSE: begin
          // Out-of-range data is dropped so the register keeps its value.
          if (load) begin
            case (addr)
              ADDR_SEC:     if (din <= DIN_W'(MAX_SEC)) sec_d = din[5:0];
              ADDR_MIN:     if (din <= DIN_W'(MAX_MIN)) min_d = din[5:0];
              ADDR_HOUR:    if (din <= DIN_W'(MAX_H24)) h24_d = din[4:0];
`ifdef HMS_ALARM_EN
              ADDR_ALM_HR:  if (din <= DIN_W'(MAX_H24)) alarm_h24_d = din[4:0];
              ADDR_ALM_MIN: if (din <= DIN_W'(MAX_MIN)) alarm_min_d = din[5:0];
`endif
              default: ;
            endcase
          end
        end
        ST_SET_AP: begin
          // Flipping AM/PM is a +/-12 hour move in 24-hour storage.
          if (inc ^ dec)
            h24_d = (h24_q < 5'd12) ? h24_q + 5'd12 : h24_q - 5'd12;
        end
        ST_SET_HR: begin
          if (step_up)      h24_d = (h24_q == MAX_H24) ? 5'd0 : h24_q + 5'd1;
          else if (step_dn) h24_d = (h24_q == 5'd0) ? MAX_H24 : h24_q - 5'd1;
        end
        ST_SET_MIN: begin
          if (step_up)      min_d = (min_q == MAX_MIN) ? 6'd0 : min_q + 6'd1;
          else if (step_dn) min_d = (min_q == 6'd0) ? MAX_MIN : min_q - 6'd1;
        end
        ST_SET_SEC: begin
          if (step_up)      sec_d = (sec_q == MAX_SEC) ? 6'd0 : sec_q + 6'd1;
          else if (step_dn) sec_d = (sec_q == 6'd0) ? MAX_SEC : sec_q - 6'd1;
        end
        default: ;
      endcase
    end
`ifdef HMS_ALARM_EN
    // Clear first, then set, so a coincident match wins over ack/ss.
    if (alarm_ack || ss)
      alarm_o_d = 1'b0;
    if (tick_upd && alarm_arm && (h24_d == alarm_h24_q) &&
        (min_d == alarm_min_q) && (sec_d == 6'd0))
      alarm_o_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      h24_q       <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      day_pulse_q <= 1'b0;
`ifdef HMS_ALARM_EN
      alarm_h24_q <= '0;
      alarm_min_q <= '0;
      alarm_o_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      h24_q       <= h24_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      day_pulse_q <= day_pulse_d;
`ifdef HMS_ALARM_EN
      alarm_h24_q <= alarm_h24_d;
      alarm_min_q <= alarm_min_d;
      alarm_o_q   <= alarm_o_d;
`endif
    end
  end

  // Display mapping is purely combinational so fmt_24 takes effect at once.
  always_comb begin
    disp12    = h24_to_12(h24_q);
    hrs       = fmt_24 ? h24_q : disp12[4:0];
    am_pm_bar = fmt_24 ? 1'b1 : disp12[5];
  end

  assign min       = min_q;
  assign sec       = sec_q;
  assign day_pulse = day_pulse_q;
  assign state_o   = state_q;
`ifdef HMS_ALARM_EN
  assign alarm_o   = alarm_o_q;
`endif

endmodule

// File: tb/tb_hms_timekeeper_cfg.sv
// Testbench for hms_timekeeper_cfg (TICK_DIV=4, DIN_W=6).
module tb_hms_timekeeper_cfg;
  import hms_pkg::*;

  logic       clk, rst, ss, sel, inc, dec, load, fmt_24;
  logic [2:0] addr;
  logic [5:0] din;
  logic [4:0] hrs;
  logic [5:0] min, sec;
  logic       am_pm_bar, day_pulse;
  logic [2:0] state_o;
  logic       alarm_arm, alarm_ack, alarm_o;

  hms_timekeeper_cfg #(.TICK_DIV(4), .DIN_W(6)) dut (
    .clk(clk), .rst(rst), .ss(ss), .sel(sel), .inc(inc), .dec(dec),
    .load(load), .addr(addr), .din(din), .fmt_24(fmt_24),
    .hrs(hrs), .min(min), .sec(sec), .am_pm_bar(am_pm_bar),
    .day_pulse(day_pulse), .state_o(state_o)
`ifdef HMS_ALARM_EN
    , .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .alarm_o(alarm_o)
`endif
  );

`ifndef HMS_ALARM_EN
  assign alarm_o = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] hrs; logic [5:0] mn; logic [5:0] sc;
    logic ap; logic [2:0] st; logic dp; logic al;
  } obs_t;

  typedef struct packed {
    logic [7:0] ctl; logic [2:0] addr; logic [5:0] din; obs_t ex;
  } step_t;

  // Control bits of a step
  localparam logic [7:0] NONE = 8'd0, SS = 8'd1, SEL = 8'd2, INC = 8'd4, DEC = 8'd8,
                         LD = 8'd16, F24 = 8'd32, RSTA = 8'd64, ACK = 8'd128;

  obs_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic step_t S(input logic [7:0] c, input int a, input int d,
                              input int h, input int m, input int s,
                              input int ap, input state_e st, input int dp);
    step_t t;
    t.ctl = c; t.addr = 3'(a); t.din = 6'(d);
    t.ex.hrs = 5'(h); t.ex.mn = 6'(m); t.ex.sc = 6'(s);
    t.ex.ap = 1'(ap); t.ex.st = st; t.ex.dp = 1'(dp); t.ex.al = 1'b0;
    return t;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.hrs = hrs; o.mn = min; o.sc = sec; o.ap = am_pm_bar;
    o.st = state_o; o.dp = day_pulse; o.al = alarm_o;
    return o;
  endfunction

  function automatic string show(input obs_t o);
    return $sformatf("%0d:%0d:%0d ap=%0b st=%0d dp=%0b al=%0b",
                     o.hrs, o.mn, o.sc, o.ap, o.st, o.dp, o.al);
  endfunction

  function automatic int h12(input int h);
    return (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
  endfunction

  task automatic drive(input step_t t);
    rst = ~t.ctl[6]; ss = t.ctl[0]; sel = t.ctl[1]; inc = t.ctl[2];
    dec = t.ctl[3]; load = t.ctl[4]; fmt_24 = t.ctl[5]; alarm_ack = t.ctl[7];
    addr = t.addr; din = t.din;
  endtask

  // Expected time after one seconds tick
  task automatic bump(inout int h, inout int m, inout int s, output int dp);
    dp = 0;
    s++;
    if (s == 60) begin s = 0; m++; end
    if (m == 60) begin m = 0; h++; end
    if (h == 24) begin h = 0; dp = 1; end
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b0; fmt_24 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(S(NONE, 0, 0, 12, 0, 0, 1, ST_RUN, 0).ex);
    e = exp_q.pop_front(); o = snap(); n_run++;
    if (o !== e) begin
      n_fail++; $display("FAIL reset_12h: got %s want %s", show(o), show(e));
    end
    fmt_24 = 1'b1; #1;
    exp_q.push_back(S(NONE, 0, 0, 0, 0, 0, 1, ST_RUN, 0).ex);
    e = exp_q.pop_front(); o = snap(); n_run++;
    if (o !== e) begin
      n_fail++; $display("FAIL reset_24h: got %s want %s", show(o), show(e));
    end
    fmt_24 = 1'b0;
  endtask

  task automatic test_run();
    step_t tb[$];
    obs_t  o, e;
    int    mh, mm, ms, cnt, dp;
    tb.push_back(S(SS, 0, 0, 12, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 3, 11, 11, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 2, 59, 11, 59, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 1, 58, 11, 59, 58, 1, ST_PAUSE, 0));
    tb.push_back(S(SS, 0, 0, 11, 59, 58, 1, ST_RUN, 0));
    mh = 11; mm = 59; ms = 58; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (cnt == 3) begin cnt = 0; bump(mh, mm, ms, dp); end
      else begin cnt++; dp = 0; end
      tb.push_back(S(NONE, 0, 0, h12(mh), mm, ms, (mh < 12) ? 1 : 0, ST_RUN, dp));
    end
    // Expected after 8 clocks: 12:00:00 PM
    tb.push_back(S(SS, 0, 0, 12, 0, 0, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 3, 23, 11, 0, 0, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 2, 59, 11, 59, 0, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 1, 59, 11, 59, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(SS, 0, 0, 11, 59, 59, 0, ST_RUN, 0));
    mh = 23; mm = 59; ms = 59; cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (cnt == 3) begin cnt = 0; bump(mh, mm, ms, dp); end
      else begin cnt++; dp = 0; end
      tb.push_back(S(NONE, 0, 0, h12(mh), mm, ms, (mh < 12) ? 1 : 0, ST_RUN, dp));
    end
    foreach (tb[i]) begin
      drive(tb[i]); exp_q.push_back(tb[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = snap(); n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL run[%0d]: got %s want %s", i, show(o), show(e));
      end
    end
  endtask

  task automatic test_set();
    step_t tb[$];
    obs_t  o, e;
    tb.push_back(S(SS, 0, 0, 12, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 3, 9, 9, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(SEL, 0, 0, 9, 0, 0, 1, ST_SET_AP, 0));
    tb.push_back(S(INC, 0, 0, 9, 0, 0, 0, ST_SET_AP, 0));
    tb.push_back(S(DEC, 0, 0, 9, 0, 0, 1, ST_SET_AP, 0));
    tb.push_back(S(INC, 0, 0, 9, 0, 0, 0, ST_SET_AP, 0));
    tb.push_back(S(SEL, 0, 0, 9, 0, 0, 0, ST_SET_HR, 0));
    tb.push_back(S(INC, 0, 0, 10, 0, 0, 0, ST_SET_HR, 0));
    tb.push_back(S(INC, 0, 0, 11, 0, 0, 0, ST_SET_HR, 0));
    tb.push_back(S(INC, 0, 0, 12, 0, 0, 1, ST_SET_HR, 0));
    tb.push_back(S(DEC, 0, 0, 11, 0, 0, 0, ST_SET_HR, 0));
    tb.push_back(S(INC | DEC, 0, 0, 11, 0, 0, 0, ST_SET_HR, 0));
    tb.push_back(S(LD, 1, 5, 11, 0, 0, 0, ST_SET_HR, 0));
    tb.push_back(S(SEL, 0, 0, 11, 0, 0, 0, ST_SET_MIN, 0));
    tb.push_back(S(DEC, 0, 0, 11, 59, 0, 0, ST_SET_MIN, 0));
    tb.push_back(S(INC, 0, 0, 11, 0, 0, 0, ST_SET_MIN, 0));
    tb.push_back(S(SEL, 0, 0, 11, 0, 0, 0, ST_SET_SEC, 0));
    tb.push_back(S(DEC, 0, 0, 11, 0, 59, 0, ST_SET_SEC, 0));
    tb.push_back(S(SEL, 0, 0, 11, 0, 59, 0, ST_SET_HR, 0));
    foreach (tb[i]) begin
      drive(tb[i]); exp_q.push_back(tb[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = snap(); n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL set[%0d]: got %s want %s", i, show(o), show(e));
      end
    end
  endtask

  task automatic test_load();
    step_t tb[$];
    obs_t  o, e;
    tb.push_back(S(SS, 0, 0, 11, 0, 59, 0, ST_RUN, 0));
    tb.push_back(S(SS, 0, 0, 11, 0, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 3, 15, 3, 0, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 2, 60, 3, 0, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 1, 63, 3, 0, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 3, 24, 3, 0, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 0, 5, 3, 0, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 6, 5, 3, 0, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(LD, 2, 59, 3, 59, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(F24, 0, 0, 15, 59, 59, 1, ST_PAUSE, 0));
    tb.push_back(S(F24 | LD, 7, 1, 15, 59, 59, 1, ST_PAUSE, 0));
    tb.push_back(S(F24 | SEL, 0, 0, 15, 59, 59, 1, ST_SET_HR, 0));
    tb.push_back(S(NONE, 0, 0, 3, 59, 59, 0, ST_SET_HR, 0));
    foreach (tb[i]) begin
      drive(tb[i]); exp_q.push_back(tb[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = snap(); n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL load[%0d]: got %s want %s", i, show(o), show(e));
      end
    end
  endtask

  task automatic test_priority();
    step_t tb[$];
    obs_t  o, e;
    tb.push_back(S(SEL, 0, 0, 3, 59, 59, 0, ST_SET_MIN, 0));
    tb.push_back(S(SS | SEL, 0, 0, 3, 59, 59, 0, ST_RUN, 0));
    tb.push_back(S(SS, 0, 0, 3, 59, 59, 0, ST_PAUSE, 0));
    tb.push_back(S(SEL, 0, 0, 3, 59, 59, 0, ST_SET_AP, 0));
    tb.push_back(S(SEL, 0, 0, 3, 59, 59, 0, ST_SET_HR, 0));
    tb.push_back(S(SEL, 0, 0, 3, 59, 59, 0, ST_SET_MIN, 0));
    tb.push_back(S(SEL, 0, 0, 3, 59, 59, 0, ST_SET_SEC, 0));
    tb.push_back(S(INC, 0, 0, 3, 59, 0, 0, ST_SET_SEC, 0));
    tb.push_back(S(RSTA | INC, 0, 0, 12, 0, 0, 1, ST_RUN, 0));
    foreach (tb[i]) begin
      drive(tb[i]); exp_q.push_back(tb[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = snap(); n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL prio[%0d]: got %s want %s", i, show(o), show(e));
      end
    end
  endtask

`ifdef HMS_ALARM_EN
  task automatic test_alarm();
    step_t tb[$];
    obs_t  o, e;
    alarm_arm = 1'b1;
    tb.push_back(S(SS, 0, 0, 12, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 4, 7, 12, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 5, 30, 12, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 3, 7, 7, 0, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 2, 29, 7, 29, 0, 1, ST_PAUSE, 0));
    tb.push_back(S(LD, 1, 59, 7, 29, 59, 1, ST_PAUSE, 0));
    tb.push_back(S(SS, 0, 0, 7, 29, 59, 1, ST_RUN, 0));
    for (int k = 0; k < 3; k++) tb.push_back(S(NONE, 0, 0, 7, 29, 59, 1, ST_RUN, 0));
    tb.push_back(S(NONE, 0, 0, 7, 30, 0, 1, ST_RUN, 0));
    tb[$].ex.al = 1'b1;
    tb.push_back(S(NONE, 0, 0, 7, 30, 0, 1, ST_RUN, 0));
    tb[$].ex.al = 1'b1;
    tb.push_back(S(ACK, 0, 0, 7, 30, 0, 1, ST_RUN, 0));
    foreach (tb[i]) begin
      drive(tb[i]); exp_q.push_back(tb[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = snap(); n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL alarm[%0d]: got %s want %s", i, show(o), show(e));
      end
    end
    alarm_arm = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; ss = 1'b0; sel = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0;
    addr = 3'd0; din = 6'd0; fmt_24 = 1'b0; alarm_arm = 1'b0; alarm_ack = 1'b0;
    #1;
    test_reset();
    test_run();
    test_set();
    test_load();
    test_priority();
`ifdef HMS_ALARM_EN
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
